fadd_sched: RTL and testbench
=============================

# fadd_sched

Round-robin scheduler that shares one combinational single-precision float adder (`add_float`) among `NREQ` requesters. It arbitrates requests, registers the operands, and returns the registered sum tagged with the winning requester index over a valid/ready response channel. It sits between the integer-side issue logic and the float adder so that the adder is instantiated exactly once.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NREQ)`: requester-index width (localparam).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B, same packing.
- `req_op`  in  NREQ  0 = add, 1 = subtract (see Configuration).
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_sum`  out  32  IEEE-754 single-precision result from the adder.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_sum`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: if any `req_valid`, the grant `g` is the first valid index at or after `rr_ptr`, searching upward with wrap. `req_ready[g]`=1 combinationally. Latch `req_a[g]`, `req_b[g]`, `req_op[g]`, and `g`, then go to CALC. `rr_ptr` ← (g+1) mod NREQ.
- CALC: adder inputs are driven only from the operand registers. Capture the adder output into `rsp_sum` and the latched index into `rsp_id`. Go to DONE.
- DONE: `rsp_valid`=1. `rsp_sum` and `rsp_id` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, a new grant may occur in the same cycle: `req_ready` is asserted as in IDLE, and the FSM goes to CALC.
  - On that handshake with no `req_valid`, go to IDLE.
- `req_ready` is 0 in CALC, and is 0 in DONE while `rsp_ready`=0.
- `rr_ptr` advances only on a grant.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `busy`=0, operand registers 0. `req_ready`=0 while `rst` is high.
- Latency: request accepted in cycle t → `rsp_valid` high in cycle t+2.
- Throughput: one result every 2 cycles with `rsp_ready` held high; one every 3 cycles when restarting from IDLE.
- Reset during CALC or DONE: the in-flight result is discarded, no response is emitted, and the FSM is in IDLE on the first edge after release.
- Requester inputs are don't-care except in the cycle where that requester's `req_ready` is high.

## Configuration
- `FADD_SCHED_SUB_EN` defined: when the latched op is 1, the scheduler inverts bit 31 of the operand-B register before it reaches the adder.
- `FADD_SCHED_SUB_EN` undefined: `req_op` is ignored, no op register is built, and B always passes unchanged.

## Structure
- Package `fadd_sched_pkg`:
  - FSM state enum (IDLE, CALC, DONE).
  - `FADD_OP_ADD`=1'b0 and `FADD_OP_SUB`=1'b1.
  - Float constant `FP_ZERO`=32'h0.
- Sub-module `rr_arb`: parameterized by NREQ. Inputs are the request vector, `rr_ptr`, and `en`. Outputs are a one-hot grant and the binary grant index. It is purely combinational; the pointer register stays in `fadd_sched`.
- One `add_float` instance.

## Test plan
- Requester 0 sends 32'h3F800000 + 32'h40000000, op=0, `rsp_ready`=1. Required: `rsp_sum`=32'h40400000 and `rsp_id`=0, two cycles after acceptance.
- Requester 2 sends a=32'h00000000 and b=32'h40490FDB. Required: `rsp_sum`=32'h40490FDB and `rsp_id`=2.
- All four requesters valid from reset release, `rsp_ready`=1. Required: grants in order 0,1,2,3, `rsp_id` sequence 0,1,2,3, one result every 2 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises. Required: `rsp_valid`, `rsp_sum` and `rsp_id` stay stable, all `req_ready`=0, and the next grant occurs in the same cycle `rsp_ready` rises.
- With `FADD_SCHED_SUB_EN` defined: 32'h3F800000 op=1 32'h3F800000. Required: `rsp_sum`=32'h00000000. Without the macro, the same stimulus must give 32'h40000000.
- Assert `rst` in the CALC cycle. Required: no `rsp_valid` and `busy`=0 after release. The next request completes normally with `rr_ptr` restarted at 0.

Source files
------------

// File: rtl/fadd_sched_pkg.sv
// fadd_sched_pkg: shared FSM state type, op encodings and float constants for fadd_sched
package fadd_sched_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic FADD_OP_ADD = 1'b0;
  localparam logic FADD_OP_SUB = 1'b1;
  localparam logic [31:0] FP_ZERO = 32'h0;
endpackage

// File: rtl/fadd_sched_add_float.sv
// add_float: combinational IEEE-754 single-precision adder, round-to-nearest-even; ports a/b in, y out
module add_float (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] l, s;
  logic [7:0]  el, es, d;
  logic [23:0] ml, ms;
  logic [49:0] wide;
  logic [26:0] al, ag, n;
  logic [27:0] sm;
  logic [4:0]  lz, sh;
  logic [9:0]  e_n, ef;
  logic [24:0] mr;
  logic [22:0] frac;
  logic        sub, sgn;
  always_comb begin
    {l, s} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
    el = (l[30:23] == 8'd0) ? 8'd1 : l[30:23];
    es = (s[30:23] == 8'd0) ? 8'd1 : s[30:23];
    ml = {|l[30:23], l[22:0]};
    ms = {|s[30:23], s[22:0]};
    d = el - es;
    // Align the smaller operand keeping guard, round and a sticky OR of everything shifted out
    wide = {ms, 26'd0} >> d;
    ag = {wide[49:24], |wide[23:0]};
    al = {ml, 3'd0};
    sub = l[31] ^ s[31];
    sm = sub ? {1'b0, al} - {1'b0, ag} : {1'b0, al} + {1'b0, ag};
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sm[i]) lz = 5'(26 - i);
    // Normalization shift stops at exponent 1 so tiny results come out subnormal
    sh = ({3'd0, lz} > el - 8'd1) ? 5'(el - 8'd1) : lz;
    n = sm[27] ? {sm[27:2], sm[1] | sm[0]} : sm[26:0] << sh;
    e_n = sm[27] ? {2'd0, el} + 10'd1 : {2'd0, el} - {5'd0, sh};
    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    ef = mr[24] ? e_n + 10'd1 : mr[23] ? e_n : 10'd0;
    frac = mr[24] ? mr[23:1] : mr[22:0];
    sgn = (sm == 28'd0) ? (l[31] & s[31]) : l[31];
    y = (ef >= 10'd255) ? {sgn, 8'hFF, 23'd0} : {sgn, ef[7:0], frac};
    // l holds the larger magnitude, so any inf/NaN operand ends up there
    if (&l[30:23]) y = (|l[22:0] || (&s[30:23] && sub)) ? 32'h7FC0_0000 : {l[31], 8'hFF, 23'd0};
  end
endmodule

// File: rtl/fadd_sched_rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or above ptr (wrapping); ports req/ptr/en in, one-hot gnt and binary idx out
module rr_arb #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);
  logic hit;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        hit = 1'b1;
        idx = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
    gnt = (en && hit) ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/fadd_sched.sv
// fadd_sched: round-robin scheduler sharing one add_float among NREQ requesters.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b/req_op per requester;
// rsp_valid/rsp_ready/rsp_sum/rsp_id response channel; busy when not IDLE.
// Define FADD_SCHED_SUB_EN to honour req_op (subtract by flipping B's sign).
module fadd_sched
  import fadd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_sum,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);
  state_t          state;
  logic [ID_W-1:0] rr_ptr, gnt_id, lat_id;
  logic [31:0]     opa, opb, b_eff, sum;
  logic [NREQ-1:0] gnt;
  logic            grant_en, take;
  // A new grant is allowed when idle, or in DONE on the very cycle the result is consumed
  assign grant_en = !rst && (state == IDLE || (state == DONE && rsp_ready));
  rr_arb #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en (grant_en),
    .gnt(gnt),
    .idx(gnt_id)
  );
  assign req_ready = gnt;
  assign take = |gnt;
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
`ifdef FADD_SCHED_SUB_EN
  logic op;
  assign b_eff = (op == FADD_OP_SUB) ? {~opb[31], opb[30:0]} : opb;
  always_ff @(posedge clk or posedge rst)
    if (rst) op <= FADD_OP_ADD;
    else if (take) op <= req_op[gnt_id];
`else
  logic unused_op;
  assign unused_op = ^{req_op, FADD_OP_ADD, FADD_OP_SUB};
  assign b_eff = opb;
`endif
  add_float u_add (
    .a(opa),
    .b(b_eff),
    .y(sum)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      lat_id <= '0;
      opa <= FP_ZERO;
      opb <= FP_ZERO;
      rsp_sum <= FP_ZERO;
      rsp_id <= '0;
    end else if (take) begin
      opa <= req_a[32*gnt_id +: 32];
      opb <= req_b[32*gnt_id +: 32];
      lat_id <= gnt_id;
      rr_ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      state <= CALC;
    end else if (state == CALC) begin
      rsp_sum <= sum;
      rsp_id <= lat_id;
      state <= DONE;
    end else if (state == DONE && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fadd_sched.sv
// tb_fadd_sched: directed self-checking bench for fadd_sched with NREQ=4
module tb_fadd_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, busy;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;
  int checks = 0;
  int errors = 0;
`ifdef FADD_SCHED_SUB_EN
  localparam logic [31:0] SUB_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] SUB_EXP = 32'h4000_0000;
`endif
  always #5 clk = ~clk;
  fadd_sched #(.NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_rsp(input string tag, input logic [31:0] sum, input logic [1:0] id);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_sum"}, rsp_sum, sum);
    chk({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
  endtask
  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_op = 4'b0000;
    req_valid = 4'b1111;
    req_a = {32'h4000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000};
    req_b = {32'h4000_0000, 32'h4049_0FDB, 32'h3F80_0000, 32'h4000_0000};
    repeat (2) @(negedge clk);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sum", rsp_sum, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    rst = 1'b0;
    #1 chk("g0_ready", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    chk("calc0_busy", {31'd0, busy}, 32'd1);
    chk("calc0_ready", {28'd0, req_ready}, 32'd0);
    chk("calc0_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk_rsp("r0", 32'h4040_0000, 2'd0);
    chk("g1_ready", {28'd0, req_ready}, 32'b0010);
    @(negedge clk);
    chk("calc1_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk_rsp("r1", 32'h4000_0000, 2'd1);
    chk("g2_ready", {28'd0, req_ready}, 32'b0100);
    @(negedge clk);
    chk("calc2_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk_rsp("r2", 32'h4049_0FDB, 2'd2);
    chk("g3_ready", {28'd0, req_ready}, 32'b1000);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk_rsp("bp", 32'h4080_0000, 2'd3);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_regrant", {28'd0, req_ready}, 32'b0001);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("calc_rg_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk_rsp("rg", 32'h4040_0000, 2'd0);
    chk("rg_noreq", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    req_a[63:32] = 32'h3F80_0000;
    req_b[63:32] = 32'h3F80_0000;
    req_op = 4'b0010;
    req_valid = 4'b0010;
    #1 chk("sub_ready", {28'd0, req_ready}, 32'b0010);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("sub", SUB_EXP, 2'd1);
    @(negedge clk);
    req_op = 4'b0000;
    req_valid = 4'b0100;
    #1 chk("pre_rst_ready", {28'd0, req_ready}, 32'b0100);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst_sum", rsp_sum, 32'd0);
    end
    req_valid = 4'b1111;
    #1 chk("ptr_restart", {28'd0, req_ready}, 32'b0001);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk_rsp("after_rst", 32'h4040_0000, 2'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
